// File: rtl/btn_conditioner.sv
// Push-button front end: 2-flop sync, tick-based debounce, registered press pulse; no backpressure.
// Level follows input after 2 + up to DEBOUNCE_TICKS*TICK_DIV cycles; press one cycle later. PRESS_ENCODE_EN adds index encoder.
module btn_conditioner #(
    parameter int N_BTN          = 8,
    parameter int TICK_DIV       = 1000,
    parameter int DEBOUNCE_TICKS = 5,
    localparam int IDX_W         = (N_BTN > 1) ? $clog2(N_BTN) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_BTN-1:0] btn_raw,
    input  logic             en,
    output logic [N_BTN-1:0] btn_level,
    output logic [N_BTN-1:0] btn_press
`ifdef PRESS_ENCODE_EN
    ,
    output logic             press_valid,
    output logic [IDX_W-1:0] press_idx,
    output logic             press_multi
`endif
);

    localparam int CNT_W = $clog2(DEBOUNCE_TICKS + 1);
    localparam int PRE_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    logic [N_BTN-1:0] sync_meta;
    logic [N_BTN-1:0] sync_btn;
    logic [N_BTN-1:0] stable;
    logic [N_BTN-1:0] stable_d;
    logic [PRE_W-1:0] pre_cnt;
    logic             tick;
    logic [CNT_W-1:0] cnt [N_BTN];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_meta <= '0;
            sync_btn  <= '0;
        end else begin
            sync_meta <= btn_raw;
            sync_btn  <= sync_meta;
        end
    end

    assign tick = (pre_cnt == PRE_W'(TICK_DIV - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pre_cnt <= '0;
        end else if (tick) begin
            pre_cnt <= '0;
        end else begin
            pre_cnt <= pre_cnt + PRE_W'(1);
        end
    end

    // Any cycle where the synced input agrees with the accepted level restarts the window.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stable <= '0;
            for (int i = 0; i < N_BTN; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < N_BTN; i++) begin
                if (sync_btn[i] == stable[i]) begin
                    cnt[i] <= '0;
                end else if (tick) begin
                    if (cnt[i] == CNT_W'(DEBOUNCE_TICKS - 1)) begin
                        stable[i] <= sync_btn[i];
                        cnt[i]    <= '0;
                    end else begin
                        cnt[i] <= cnt[i] + CNT_W'(1);
                    end
                end
            end
        end
    end

    // Rising edges seen while en is low are dropped, not held for later.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stable_d  <= '0;
            btn_press <= '0;
        end else begin
            stable_d  <= stable;
            btn_press <= en ? (stable & ~stable_d) : '0;
        end
    end

    assign btn_level = stable;

`ifdef PRESS_ENCODE_EN
    always_comb begin
        press_idx   = '0;
        press_valid = |btn_press;
        press_multi = |(btn_press & (btn_press - N_BTN'(1)));
        for (int i = N_BTN - 1; i >= 0; i--) begin
            if (btn_press[i]) begin
                press_idx = IDX_W'(i);
            end
        end
    end
`endif

endmodule
